sram_sequencer: RTL and testbench

- Owns the single 512K x 8 acquisition SRAM and sequences every access to it.
- Arbitrates between three requesters: acquisition writes from the disc reader, MCU data-register writes and MCU data-register reads.
- Holds the 19-bit SRAM address pointer and raises EMPTY/FULL status.
- Replaces the ad-hoc write controller and address counter in the top level. All inputs are already synchronised to CLOCK.

---
 rtl/sram_seq_pkg.sv | 25 ++
 rtl/sram_sequencer_if.sv | 40 ++++
 rtl/sram_addr_pointer.sv | 91 +++++++++
 rtl/sram_sequencer.sv | 178 +++++++++++++++++
 tb/tb_sram_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_seq_pkg.sv
// Shared definitions for the acquisition SRAM sequencer: FSM states,
// requester identities and ADDR_LOAD strobe bit positions.
package sram_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_WAIT,
    RD_DONE
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_ACQ_WR,
    REQ_MCU_WR,
    REQ_MCU_RD
  } req_id_t;

  localparam int LOAD_LOW   = 0;
  localparam int LOAD_HIGH  = 1;
  localparam int LOAD_UPPER = 2;

endpackage

// File: rtl/sram_sequencer_if.sv
// Requester, status and SRAM pin bundle of the sequencer; the sequencer
// takes the slave view, whoever drives requests and models the SRAM takes master.
interface sram_sequencer_if #(parameter int ADDR_WIDTH = 19);

  logic                  ACQ_WR_REQ;
  logic [7:0]            ACQ_WR_DATA;
  logic                  MCU_WR_REQ;
  logic [7:0]            MCU_WR_DATA;
  logic                  MCU_RD_REQ;
  logic [2:0]            ADDR_LOAD;
  logic [7:0]            ADDR_LOAD_DATA;
  logic                  OVR_CLR;
  logic [ADDR_WIDTH-1:0] SRAM_A;
  logic [7:0]            SRAM_DQ_OUT;
  logic                  SRAM_DQ_OE;
  logic [7:0]            SRAM_DQ_IN;
  logic                  SRAM_WE_n;
  logic                  SRAM_OE_n;
  logic [7:0]            RD_DATA;
  logic                  RD_VALID;
  logic                  BUSY;
  logic                  EMPTY;
  logic                  FULL;
  logic                  ACQ_OVERRUN;

  modport slave (
    input  ACQ_WR_REQ, ACQ_WR_DATA, MCU_WR_REQ, MCU_WR_DATA, MCU_RD_REQ,
    input  ADDR_LOAD, ADDR_LOAD_DATA, OVR_CLR, SRAM_DQ_IN,
    output SRAM_A, SRAM_DQ_OUT, SRAM_DQ_OE, SRAM_WE_n, SRAM_OE_n,
    output RD_DATA, RD_VALID, BUSY, EMPTY, FULL, ACQ_OVERRUN
  );

  modport master (
    output ACQ_WR_REQ, ACQ_WR_DATA, MCU_WR_REQ, MCU_WR_DATA, MCU_RD_REQ,
    output ADDR_LOAD, ADDR_LOAD_DATA, OVR_CLR, SRAM_DQ_IN,
    input  SRAM_A, SRAM_DQ_OUT, SRAM_DQ_OE, SRAM_WE_n, SRAM_OE_n,
    input  RD_DATA, RD_VALID, BUSY, EMPTY, FULL, ACQ_OVERRUN
  );

endinterface

// File: rtl/sram_addr_pointer.sv
// SRAM address pointer: saturating increment, byte-wise load with a one-deep
// deferred-load slot, and EMPTY/FULL status.
module sram_addr_pointer
  import sram_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  idle,
  input  logic                  grant,
  input  logic                  inc,
  input  logic                  wr_done,
  input  logic [2:0]            load,
  input  logic [7:0]            load_data,
  output logic [ADDR_WIDTH-1:0] ptr,
  output logic                  empty,
  output logic                  full
);

  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  full_q, full_d;
  logic                  slot_vld_q, slot_vld_d;
  logic [2:0]            slot_sel_q, slot_sel_d;
  logic [7:0]            slot_data_q, slot_data_d;

  function automatic logic [ADDR_WIDTH-1:0] load_bytes(
    input logic [ADDR_WIDTH-1:0] cur,
    input logic [2:0]            sel,
    input logic [7:0]            data
  );
    logic [ADDR_WIDTH-1:0] r;
    r = cur;
    if (sel[LOAD_LOW])   r[7:0]            = data;
    if (sel[LOAD_HIGH])  r[15:8]           = data;
    if (sel[LOAD_UPPER]) r[ADDR_WIDTH-1:16] = data[ADDR_WIDTH-17:0];
    return r;
  endfunction

  // Increment lands first (on exit of an access), any deferred load follows
  // in the next IDLE cycle, so a load issued mid-access wins over the increment.
  always_comb begin
    ptr_d       = ptr_q;
    full_d      = full_q;
    slot_vld_d  = slot_vld_q;
    slot_sel_d  = slot_sel_q;
    slot_data_d = slot_data_q;
    if (inc) begin
      if (ptr_q != PTR_MAX) ptr_d = ptr_q + 1'b1;
      else if (wr_done)     full_d = 1'b1;
    end
    if (idle && slot_vld_q) begin
      ptr_d      = load_bytes(ptr_d, slot_sel_q, slot_data_q);
      full_d     = 1'b0;
      slot_vld_d = 1'b0;
    end
    if (|load) begin
      if (idle && !grant) begin
        ptr_d  = load_bytes(ptr_d, load, load_data);
        full_d = 1'b0;
      end else begin
        slot_vld_d  = 1'b1;
        slot_sel_d  = load;
        slot_data_d = load_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      full_q      <= 1'b0;
      slot_vld_q  <= 1'b0;
      slot_sel_q  <= '0;
      slot_data_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      full_q      <= full_d;
      slot_vld_q  <= slot_vld_d;
      slot_sel_q  <= slot_sel_d;
      slot_data_q <= slot_data_d;
    end
  end

  assign ptr   = ptr_q;
  assign empty = (ptr_q == '0);
  assign full  = full_q;

endmodule

// File: rtl/sram_sequencer.sv
// Sole owner of the 512K x 8 acquisition SRAM: captures acquisition and MCU
// requests, arbitrates them in IDLE and runs the write/read strobe timing.
module sram_sequencer
  import sram_seq_pkg::*;
#(
  parameter int ADDR_WIDTH      = 19,
  parameter int WR_PULSE_CYCLES = 1,
  parameter int RD_WAIT_CYCLES  = 2
) (
  input  logic             CLOCK,
  input  logic             RESET_n,
  sram_sequencer_if.slave  bus
);

  localparam logic [3:0] WR_INIT = 4'(WR_PULSE_CYCLES - 1);
  localparam logic [3:0] RD_INIT = 4'(RD_WAIT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       acq_pend_q, acq_pend_d, mcu_wr_pend_q, mcu_wr_pend_d, mcu_rd_pend_q, mcu_rd_pend_d;
  logic [7:0] acq_data_q, acq_data_d, mcu_data_q, mcu_data_d;
  logic       ovr_q, ovr_d, we_n_q, we_n_d, oe_n_q, oe_n_d, dq_oe_q, dq_oe_d, rd_valid_q, rd_valid_d;
  logic [7:0] dq_out_q, dq_out_d, rd_data_q, rd_data_d;

  req_id_t    grant_id;
  logic [7:0] acq_byte, mcu_byte;
  logic       ovr_set, inc, wr_done, full, empty;
  logic [ADDR_WIDTH-1:0] ptr;

  always_comb begin
    grant_id = REQ_NONE;
    if (state_q == IDLE) begin
      if (acq_pend_q)         grant_id = REQ_ACQ_WR;
      else if (mcu_wr_pend_q) grant_id = REQ_MCU_WR;
      else if (mcu_rd_pend_q) grant_id = REQ_MCU_RD;
    end
  end

  // A strobe arriving while its flag is still set merges into that request;
  // the newest byte is forwarded so a same-cycle grant carries it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_n_d     = we_n_q;
    oe_n_d     = oe_n_q;
    dq_oe_d    = dq_oe_q;
    dq_out_d   = dq_out_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    inc        = 1'b0;
    wr_done    = 1'b0;

    acq_byte      = bus.ACQ_WR_REQ ? bus.ACQ_WR_DATA : acq_data_q;
    mcu_byte      = bus.MCU_WR_REQ ? bus.MCU_WR_DATA : mcu_data_q;
    acq_data_d    = acq_byte;
    mcu_data_d    = mcu_byte;
    acq_pend_d    = acq_pend_q    ? (grant_id != REQ_ACQ_WR) : bus.ACQ_WR_REQ;
    mcu_wr_pend_d = mcu_wr_pend_q ? (grant_id != REQ_MCU_WR) : bus.MCU_WR_REQ;
    mcu_rd_pend_d = mcu_rd_pend_q ? (grant_id != REQ_MCU_RD) : bus.MCU_RD_REQ;
    ovr_set       = bus.ACQ_WR_REQ && acq_pend_q;

    case (state_q)
      IDLE: begin
        if (grant_id == REQ_ACQ_WR || grant_id == REQ_MCU_WR) begin
          if (full) begin
            // Memory is full: the write is consumed without touching the SRAM.
            if (grant_id == REQ_ACQ_WR) ovr_set = 1'b1;
          end else begin
            state_d  = WR_SETUP;
            dq_oe_d  = 1'b1;
            dq_out_d = (grant_id == REQ_ACQ_WR) ? acq_byte : mcu_byte;
          end
        end else if (grant_id == REQ_MCU_RD) begin
          state_d = RD_WAIT;
          oe_n_d  = 1'b0;
          cnt_d   = RD_INIT;
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        we_n_d  = 1'b0;
        cnt_d   = WR_INIT;
      end
      WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = WR_HOLD;
          we_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_HOLD: begin
        state_d = IDLE;
        dq_oe_d = 1'b0;
        inc     = 1'b1;
        wr_done = 1'b1;
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RD_DONE;
          oe_n_d     = 1'b1;
          rd_data_d  = bus.SRAM_DQ_IN;
          rd_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_DONE: begin
        state_d = IDLE;
        inc     = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    ovr_d = ovr_set ? 1'b1 : (bus.OVR_CLR ? 1'b0 : ovr_q);
  end

  always_ff @(posedge CLOCK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      acq_pend_q    <= 1'b0;
      mcu_wr_pend_q <= 1'b0;
      mcu_rd_pend_q <= 1'b0;
      acq_data_q    <= '0;
      mcu_data_q    <= '0;
      ovr_q         <= 1'b0;
      we_n_q        <= 1'b1;
      oe_n_q        <= 1'b1;
      dq_oe_q       <= 1'b0;
      dq_out_q      <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acq_pend_q    <= acq_pend_d;
      mcu_wr_pend_q <= mcu_wr_pend_d;
      mcu_rd_pend_q <= mcu_rd_pend_d;
      acq_data_q    <= acq_data_d;
      mcu_data_q    <= mcu_data_d;
      ovr_q         <= ovr_d;
      we_n_q        <= we_n_d;
      oe_n_q        <= oe_n_d;
      dq_oe_q       <= dq_oe_d;
      dq_out_q      <= dq_out_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  sram_addr_pointer #(.ADDR_WIDTH(ADDR_WIDTH)) u_ptr (
    .clk       (CLOCK),
    .rst_n     (RESET_n),
    .idle      (state_q == IDLE),
    .grant     (grant_id != REQ_NONE),
    .inc       (inc),
    .wr_done   (wr_done),
    .load      (bus.ADDR_LOAD),
    .load_data (bus.ADDR_LOAD_DATA),
    .ptr       (ptr),
    .empty     (empty),
    .full      (full)
  );

  assign bus.SRAM_A      = ptr;
  assign bus.SRAM_DQ_OUT = dq_out_q;
  assign bus.SRAM_DQ_OE  = dq_oe_q;
  assign bus.SRAM_WE_n   = we_n_q;
  assign bus.SRAM_OE_n   = oe_n_q;
  assign bus.RD_DATA     = rd_data_q;
  assign bus.RD_VALID    = rd_valid_q;
  assign bus.BUSY        = (state_q != IDLE) | acq_pend_q | mcu_wr_pend_q | mcu_rd_pend_q;
  assign bus.EMPTY       = empty;
  assign bus.FULL        = full;
  assign bus.ACQ_OVERRUN = ovr_q;

endmodule

// File: tb/tb_sram_sequencer.sv
// Directed bench for sram_sequencer: expected SRAM writes and reads are queued
// by the stimulus and matched by a monitor on each WE_n fall / RD_VALID pulse.
module tb_sram_sequencer;

  typedef struct {
    logic [18:0] a;
    logic [7:0]  d;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   we_cnt = 0;
  int   rd_cnt = 0;
  logic prev_we = 1'b1;
  exp_t wr_q[$];
  exp_t rd_q[$];
  logic [7:0] mem [logic [18:0]];

  always #5 clk = ~clk;

  sram_sequencer_if bus ();

  sram_sequencer dut (
    .CLOCK   (clk),
    .RESET_n (rst_n),
    .bus     (bus)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // SRAM model: read data presented half a cycle ahead of the capturing edge.
  always @(negedge clk)
    bus.SRAM_DQ_IN <= mem.exists(bus.SRAM_A) ? mem[bus.SRAM_A] : 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_we && !bus.SRAM_WE_n) begin
        we_cnt <= we_cnt + 1;
        if (wr_q.size() == 0) begin
          check("unexpected_we_pulse", {13'd0, bus.SRAM_A}, 32'hFFFF_FFFF);
        end else begin
          check("wr_addr", {13'd0, bus.SRAM_A}, {13'd0, wr_q[0].a});
          check("wr_data", {24'd0, bus.SRAM_DQ_OUT}, {24'd0, wr_q[0].d});
          check("wr_dq_oe", {31'd0, bus.SRAM_DQ_OE}, 32'd1);
          void'(wr_q.pop_front());
        end
      end
      if (bus.RD_VALID) begin
        rd_cnt <= rd_cnt + 1;
        if (rd_q.size() == 0) begin
          check("unexpected_rd_valid", {24'd0, bus.RD_DATA}, 32'hFFFF_FFFF);
        end else begin
          check("rd_addr", {13'd0, bus.SRAM_A}, {13'd0, rd_q[0].a});
          check("rd_data", {24'd0, bus.RD_DATA}, {24'd0, rd_q[0].d});
          void'(rd_q.pop_front());
        end
      end
      check("we_oe_exclusive", {31'd0, bus.SRAM_WE_n | bus.SRAM_OE_n}, 32'd1);
      check("oe_off_when_driving", {31'd0, !bus.SRAM_DQ_OE | bus.SRAM_OE_n}, 32'd1);
    end
    prev_we <= bus.SRAM_WE_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acq_wr(input logic [7:0] d);
    bus.ACQ_WR_DATA = d;
    bus.ACQ_WR_REQ  = 1'b1;
    tick();
    bus.ACQ_WR_REQ  = 1'b0;
  endtask

  task automatic mcu_wr(input logic [7:0] d);
    bus.MCU_WR_DATA = d;
    bus.MCU_WR_REQ  = 1'b1;
    tick();
    bus.MCU_WR_REQ  = 1'b0;
  endtask

  task automatic mcu_rd();
    bus.MCU_RD_REQ = 1'b1;
    tick();
    bus.MCU_RD_REQ = 1'b0;
  endtask

  task automatic ovr_clr();
    bus.OVR_CLR = 1'b1;
    tick();
    bus.OVR_CLR = 1'b0;
  endtask

  task automatic addr_load(input logic [2:0] sel, input logic [7:0] d);
    bus.ADDR_LOAD      = sel;
    bus.ADDR_LOAD_DATA = d;
    tick();
    bus.ADDR_LOAD      = 3'b000;
  endtask

  task automatic load_addr(input logic [18:0] a);
    addr_load(3'b100, {5'd0, a[18:16]});
    addr_load(3'b010, a[15:8]);
    addr_load(3'b001, a[7:0]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.BUSY && n < 200) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, bus.BUSY}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int r0;
    bus.ACQ_WR_REQ = 0; bus.ACQ_WR_DATA = 0; bus.MCU_WR_REQ = 0; bus.MCU_WR_DATA = 0;
    bus.MCU_RD_REQ = 0; bus.ADDR_LOAD = 0; bus.ADDR_LOAD_DATA = 0; bus.OVR_CLR = 0;
    mem[19'h00102] = 8'h5C;
    mem[19'h7FFFF] = 8'h99;

    #1 rst_n = 1'b0;
    #2;
    check("rst_a",     {13'd0, bus.SRAM_A}, 32'd0);
    check("rst_we_n",  {31'd0, bus.SRAM_WE_n}, 32'd1);
    check("rst_oe_n",  {31'd0, bus.SRAM_OE_n}, 32'd1);
    check("rst_dq_oe", {31'd0, bus.SRAM_DQ_OE}, 32'd0);
    check("rst_empty", {31'd0, bus.EMPTY}, 32'd1);
    check("rst_full",  {31'd0, bus.FULL}, 32'd0);
    check("rst_busy",  {31'd0, bus.BUSY}, 32'd0);
    check("rst_ovr",   {31'd0, bus.ACQ_OVERRUN}, 32'd0);
    check("rst_rdv",   {31'd0, bus.RD_VALID}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Single MCU write with edge-by-edge latency
    load_addr(19'h00010);
    check("t1_load_a", {13'd0, bus.SRAM_A}, 32'h10);
    check("t1_empty",  {31'd0, bus.EMPTY}, 32'd0);
    w0 = we_cnt;
    wr_q.push_back('{a: 19'h00010, d: 8'hA5});
    bus.MCU_WR_DATA = 8'hA5;
    bus.MCU_WR_REQ  = 1'b1;
    tick();
    bus.MCU_WR_REQ  = 1'b0;
    check("t1_busy_k",   {31'd0, bus.BUSY}, 32'd1);
    check("t1_we_k",     {31'd0, bus.SRAM_WE_n}, 32'd1);
    tick();
    check("t1_dqoe_k1",  {31'd0, bus.SRAM_DQ_OE}, 32'd1);
    check("t1_we_k1",    {31'd0, bus.SRAM_WE_n}, 32'd1);
    tick();
    check("t1_we_k2",    {31'd0, bus.SRAM_WE_n}, 32'd0);
    wait_idle();
    check("t1_final_a",  {13'd0, bus.SRAM_A}, 32'h11);
    check("t1_we_pulses", we_cnt - w0, 32'd1);

    // Three-way same-cycle arbitration
    load_addr(19'h00100);
    r0 = rd_cnt;
    wr_q.push_back('{a: 19'h00100, d: 8'h11});
    wr_q.push_back('{a: 19'h00101, d: 8'h22});
    rd_q.push_back('{a: 19'h00102, d: 8'h5C});
    bus.ACQ_WR_DATA = 8'h11; bus.ACQ_WR_REQ = 1'b1;
    bus.MCU_WR_DATA = 8'h22; bus.MCU_WR_REQ = 1'b1;
    bus.MCU_RD_REQ  = 1'b1;
    tick();
    bus.ACQ_WR_REQ = 1'b0; bus.MCU_WR_REQ = 1'b0; bus.MCU_RD_REQ = 1'b0;
    wait_idle();
    check("t2_final_a", {13'd0, bus.SRAM_A}, 32'h103);
    check("t2_rd_pulses", rd_cnt - r0, 32'd1);

    // Top-of-memory: FULL, dropped write, read at max, clear by load
    load_addr(19'h7FFFF);
    check("t3_load_a", {13'd0, bus.SRAM_A}, 32'h7FFFF);
    wr_q.push_back('{a: 19'h7FFFF, d: 8'hC3});
    acq_wr(8'hC3);
    wait_idle();
    check("t3_full_set", {31'd0, bus.FULL}, 32'd1);
    check("t3_a_at_max", {13'd0, bus.SRAM_A}, 32'h7FFFF);
    check("t3_ovr_clear", {31'd0, bus.ACQ_OVERRUN}, 32'd0);
    w0 = we_cnt;
    acq_wr(8'h3C);
    wait_idle();
    check("t3_no_we_pulse", we_cnt - w0, 32'd0);
    check("t3_ovr_set", {31'd0, bus.ACQ_OVERRUN}, 32'd1);
    ovr_clr();
    check("t3_ovr_cleared", {31'd0, bus.ACQ_OVERRUN}, 32'd0);
    rd_q.push_back('{a: 19'h7FFFF, d: 8'h99});
    mcu_rd();
    wait_idle();
    check("t3_rd_a_max", {13'd0, bus.SRAM_A}, 32'h7FFFF);
    check("t3_rd_full", {31'd0, bus.FULL}, 32'd1);
    addr_load(3'b001, 8'h00);
    check("t3_load_clr_full", {31'd0, bus.FULL}, 32'd0);
    check("t3_load_a2", {13'd0, bus.SRAM_A}, 32'h7FF00);

    // Back-to-back ACQ strobes: second byte replaces first
    load_addr(19'h00200);
    w0 = we_cnt;
    wr_q.push_back('{a: 19'h00200, d: 8'h02});
    acq_wr(8'h01);
    acq_wr(8'h02);
    wait_idle();
    check("t4_ovr", {31'd0, bus.ACQ_OVERRUN}, 32'd1);
    check("t4_we_pulses", we_cnt - w0, 32'd1);
    check("t4_final_a", {13'd0, bus.SRAM_A}, 32'h201);
    ovr_clr();
    check("t4_ovr_cleared", {31'd0, bus.ACQ_OVERRUN}, 32'd0);
    wr_q.push_back('{a: 19'h00201, d: 8'hBB});
    acq_wr(8'hAA);
    bus.OVR_CLR = 1'b1;
    acq_wr(8'hBB);
    bus.OVR_CLR = 1'b0;
    check("t4_set_beats_clr", {31'd0, bus.ACQ_OVERRUN}, 32'd1);
    wait_idle();
    ovr_clr();

    // Address load deferred behind an in-flight write
    load_addr(19'h00005);
    wr_q.push_back('{a: 19'h00005, d: 8'h77});
    wr_q.push_back('{a: 19'h00040, d: 8'h88});
    mcu_wr(8'h77);
    tick();
    bus.ADDR_LOAD = 3'b001; bus.ADDR_LOAD_DATA = 8'h40;
    bus.MCU_WR_DATA = 8'h88; bus.MCU_WR_REQ = 1'b1;
    tick();
    bus.ADDR_LOAD = 3'b000; bus.MCU_WR_REQ = 1'b0;
    wait_idle();
    check("t5_final_a", {13'd0, bus.SRAM_A}, 32'h41);

    // Asynchronous reset in the middle of WR_PULSE
    load_addr(19'h00300);
    wr_q.push_back('{a: 19'h00300, d: 8'h55});
    mcu_wr(8'h55);
    tick();
    tick();
    check("t6_in_pulse", {31'd0, bus.SRAM_WE_n}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_we_n", {31'd0, bus.SRAM_WE_n}, 32'd1);
    check("t6_dq_oe", {31'd0, bus.SRAM_DQ_OE}, 32'd0);
    check("t6_a", {13'd0, bus.SRAM_A}, 32'd0);
    check("t6_busy", {31'd0, bus.BUSY}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    check("wr_queue_drained", wr_q.size(), 32'd0);
    check("rd_queue_drained", rd_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
